// File: rtl/vec_word_serializer.sv
// Walks a captured 4096-bit vector one 32-bit word per valid/ready handshake, driving the
// external 128:1 mux select. Optional build macro LANE_SKIP_EN enables per-word mask skipping.
module vec_word_serializer (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [4095:0] load_data,
  input  logic [6:0]    load_last_idx,
  input  logic [127:0]  load_mask,
  output logic [4095:0] mux_in,
  output logic [6:0]    mux_select,
  input  logic [31:0]   mux_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [6:0]    out_index,
  output logic          out_last,
  output logic          done
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      idx_q, idx_d;
  logic [6:0]      last_q, last_d;
  logic            done_q, done_d;
  logic [4095:0]   mux_in_q, mux_in_d;

  logic            first_found;
  logic [6:0]      first_idx;
  logic            next_found;
  logic [6:0]      next_idx;
  logic            is_last;

`ifdef LANE_SKIP_EN
  logic [127:0]    mask_q, mask_d;

  // Lowest index k with from <= k <= last and mask[k] set; result is {found, index}.
  function automatic logic [7:0] find_eligible(input logic [127:0] mask,
                                               input logic [6:0]   last,
                                               input logic [7:0]   from);
    logic [7:0] res;
    res = 8'd0;
    for (int k = 127; k >= 0; k--) begin
      if (mask[k] && (k <= int'(last)) && (k >= int'(from))) begin
        res = {1'b1, k[6:0]};
      end
    end
    return res;
  endfunction

  logic [7:0] first_res;
  logic [7:0] next_res;

  always_comb begin
    first_res   = find_eligible(load_mask, load_last_idx, 8'd0);
    next_res    = find_eligible(mask_q, last_q, {1'b0, idx_q} + 8'd1);
    first_found = first_res[7];
    first_idx   = first_res[6:0];
    next_found  = next_res[7];
    next_idx    = next_res[6:0];
    is_last     = !next_found;
  end
`else
  logic unused_load_mask;
  assign unused_load_mask = ^load_mask;

  always_comb begin
    first_found = 1'b1;
    first_idx   = 7'd0;
    // idx never passes last_q, so the +1 cannot wrap while streaming.
    next_found  = (idx_q != last_q);
    next_idx    = idx_q + 7'd1;
    is_last     = (idx_q == last_q);
  end
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The producer holds valid and its payload stable until that edge; ready may toggle freely.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    mux_in_d = mux_in_q;
    done_d   = 1'b0;
`ifdef LANE_SKIP_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          mux_in_d = load_data;
          last_d   = load_last_idx;
`ifdef LANE_SKIP_EN
          mask_d   = load_mask;
`endif
          if (first_found) begin
            idx_d   = first_idx;
            state_d = STREAM;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = next_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 7'd0;
      last_q  <= 7'd0;
      done_q  <= 1'b0;
`ifdef LANE_SKIP_EN
      mask_q  <= 128'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef LANE_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Vector hold register carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mux_in_q <= mux_in_d;
  end

  assign load_ready = (state_q == IDLE);
  assign out_valid  = (state_q == STREAM);
  assign out_last   = (state_q == STREAM) && is_last;
  assign mux_in     = mux_in_q;
  assign mux_select = idx_q;
  assign out_index  = idx_q;
  assign out_data   = mux_data;
  assign done       = done_q;

endmodule

// File: tb/tb_vec_word_serializer.sv
// Bench for vec_word_serializer: table of vectors plus hand-written reset/hold/mask sequences.
// Expected words go to a scoreboard queue on load and are checked at each output handshake.
`timescale 1ns/1ps
module tb_vec_word_serializer;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [4095:0] load_data;
  logic [6:0]    load_last_idx;
  logic [127:0]  load_mask;
  logic [4095:0] mux_in;
  logic [6:0]    mux_select;
  logic [31:0]   mux_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [6:0]    out_index;
  logic          out_last;
  logic          done;

  vec_word_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last_idx (load_last_idx),
    .load_mask     (load_mask),
    .mux_in        (mux_in),
    .mux_select    (mux_select),
    .mux_data      (mux_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .done          (done)
  );

  // The external word mux.
  assign mux_data = mux_in[{mux_select, 5'b0} +: 32];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];   // {last, index, data}

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit elig(input logic [127:0] m, input int k);
`ifdef LANE_SKIP_EN
    return m[k];
`else
    return m[k] | 1'b1;
`endif
  endfunction

  function automatic logic [4095:0] mk_vec(input logic [31:0] base);
    logic [4095:0] v;
    for (int k = 0; k < 128; k++) begin
      if (base == 32'd0) v[k*32 +: 32] = $urandom;
      else               v[k*32 +: 32] = base + 32'(k);
    end
    return v;
  endfunction

  logic        done_arm = 1'b0;
  logic        zero_load = 1'b0;
  logic        stall_prev = 1'b0;
  logic [38:0] stall_val;

  always @(negedge clk) begin
    logic        exp_done_now;
    logic [39:0] e;
    if (rst) begin
      done_arm   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      exp_done_now = done_arm;
      done_arm     = 1'b0;
      chk("done_pulse", done, exp_done_now);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_index, out_data}, stall_val);
      end
      if (load_valid && load_ready && zero_load) done_arm = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got index %0d data %h expected none", out_index, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", {out_last, out_index, out_data}, e);
          if (out_last) done_arm = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_index, out_data};
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
  int rcnt = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rcnt % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      rcnt++;
    end
  end

  task automatic load_vec(input logic [4095:0] v, input logic [6:0] last,
                          input logic [127:0] m, output int n_words);
    int waited;
    int first_k;
    logic [39:0] e;
    waited        = 0;
    n_words       = 0;
    first_k       = 0;
    load_data     = v;
    load_last_idx = last;
    load_mask     = m;
    load_valid    = 1'b1;
    while (!load_ready && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: load_ready=0 after %0d cycles, required 1", waited);
      load_valid = 1'b0;
      return;
    end
    if (waited > 0) chk("held_load_accept_at_done", done, 1);
    for (int k = 0; k <= int'(last); k++) begin
      if (elig(m, k)) begin
        if (n_words == 0) first_k = k;
        exp_q.push_back({1'b0, 7'(k), v[k*32 +: 32]});
        n_words++;
      end
    end
    if (n_words > 0) begin
      e = exp_q.pop_back();
      e[39] = 1'b1;
      exp_q.push_back(e);
    end
    zero_load = (n_words == 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    zero_load  = 1'b0;
    if (n_words > 0) chk("first_word_latency", {out_valid, out_index}, {1'b1, 7'(first_k)});
    else             chk("zero_load_no_valid", out_valid, 0);
  endtask

  // Called in the cycle after the accepting edge; that cycle counts as 1.
  task automatic wait_done(input int exp_cycles, input string name);
    int c;
    c = 1;
    while (!done && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done never seen, waited %0d cycles", name, c);
    end else begin
      if (exp_cycles > 0) chk(name, c, exp_cycles);
      chk("ready_at_done", {load_ready, out_valid}, 2'b10);
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [6:0]   last;
    logic [31:0]  base;
    logic [127:0] mask;
    int           mode;
    int           exp_words;
    int           exp_cyc;    // 0 = not checked (stalling consumer)
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [4095:0] v;
    int n;

    tbl[0] = '{7'd127, 32'hA500_0000, {128{1'b1}}, 0, 128, 129};
    tbl[1] = '{7'd0,   32'hDEAD_BEEF, {128{1'b1}}, 0, 1,   2};
    tbl[2] = '{7'd3,   32'h1111_0000, {128{1'b1}}, 1, 4,   0};
    tbl[3] = '{7'd9,   32'h0,         {128{1'b1}}, 2, 10,  0};
`ifdef LANE_SKIP_EN
    tbl[4] = '{7'd7,   32'h2222_0000, 128'h00A5,   0, 4,   5};
`else
    tbl[4] = '{7'd7,   32'h2222_0000, 128'h00A5,   0, 8,   9};
`endif
    tbl[5] = '{7'd126, 32'h0,         {128{1'b1}}, 0, 127, 128};

    // Reset, with a load presented the whole time.
    rst           = 1'b1;
    load_valid    = 1'b1;
    load_data     = mk_vec(32'h0);
    load_last_idx = 7'd5;
    load_mask     = {128{1'b1}};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {out_valid, load_ready, done, out_last}, 4'b0100);
    chk("reset_idx", {mux_select, out_index}, 14'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_ctrl", {out_valid, load_ready, done}, 3'b010);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      ready_mode = tbl[i].mode;
      v = mk_vec(tbl[i].base);
      load_vec(v, tbl[i].last, tbl[i].mask, n);
      chk("table_word_count", n, tbl[i].exp_words);
      wait_done(tbl[i].exp_cyc, "table_done_cycle");
      ready_mode = 0;
      chk("table_queue_drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
    end

    // Second load held during streaming: accepted only at the done cycle.
    ready_mode = 0;
    load_vec(mk_vec(32'h3333_0000), 7'd2, {128{1'b1}}, n);
    load_vec(mk_vec(32'h4444_0000), 7'd1, {128{1'b1}}, n);
    wait_done(3, "held_load_done_cycle");
    chk("held_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a 10-word vector.
    @(posedge clk);
    #1;
    load_vec(mk_vec(32'h5555_0000), 7'd9, {128{1'b1}}, n);
    repeat (5) @(posedge clk);
    #1;
    chk("idx_before_rst", out_index, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_ctrl", {out_valid, load_ready, done, out_last}, 4'b0100);
    chk("mid_rst_idx", out_index, 0);
    load_vec(mk_vec(32'h6666_0000), 7'd2, {128{1'b1}}, n);
    wait_done(4, "after_rst_done_cycle");
    chk("after_rst_queue_drained", exp_q.size(), 0);

    // Mask patterns.
    @(posedge clk);
    #1;
    load_vec(mk_vec(32'h7777_0000), 7'd15, 128'h8421, n);
`ifdef LANE_SKIP_EN
    chk("mask_8421_count", n, 4);
    wait_done(5, "mask_8421_done_cycle");
`else
    chk("mask_ignored_count", n, 16);
    wait_done(17, "mask_ignored_done_cycle");
`endif
    @(posedge clk);
    #1;
    load_vec(mk_vec(32'h8888_0000), 7'd15, 128'h0, n);
`ifdef LANE_SKIP_EN
    chk("mask_zero_count", n, 0);
    wait_done(1, "mask_zero_done_cycle");
`else
    chk("mask_zero_ignored_count", n, 16);
    wait_done(17, "mask_zero_ignored_done_cycle");
`endif
    chk("final_queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
